div_request_sequencer: RTL and testbench
========================================

Name: div_request_sequencer

Overview:
- Controller that sits between decode/issue and the shared unsigned divider.
- Accepts signed and unsigned DIV/REM ops and converts operands to magnitudes before pulsing the divider.
- Sign-corrects the result and holds it on a single writeback slot until acknowledged.
- Short-circuits divide-by-zero, and reuses the last quotient/remainder when a DIV/REM pair shares operands.

Parameters:
- DATA_WIDTH, 32: operand/result width; equals divider DATA_WIDTH.
- ENABLE_REUSE, 1: 1 enables the last-operand quotient/remainder reuse path.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- possible_issue  in  1  decode has a candidate op for this unit
- new_request  in  1  op issued this cycle; legal only when ready=1
- id  in  id_t  instruction id
- rs1  in  DATA_WIDTH  dividend
- rs2  in  DATA_WIDTH  divisor
- op  in  div_op_t(2)  DIV=0, DIVU=1, REM=2, REMU=3
- ready  out  1  can accept new_request
- div_start  out  1  one-cycle start pulse to divider
- div_dividend  out  DATA_WIDTH  magnitude of dividend
- div_divisor  out  DATA_WIDTH  magnitude of divisor
- div_quotient  in  DATA_WIDTH  divider quotient
- div_remainder  in  DATA_WIDTH  divider remainder
- div_done  in  1  one-cycle completion pulse
- div_divisor_is_zero  in  1  divider zero flag; sampled only for consistency checking
- wb_done  out  1  result valid
- wb_id  out  id_t  id of result
- wb_rd  out  DATA_WIDTH  result
- wb_ack  in  1  writeback accepts result this cycle

Behaviour:
- Reset values: ready=1, div_start=0, wb_done=0, wb_id=0, wb_rd=0, div_dividend=0, div_divisor=0; state IDLE; reuse entry invalid.
- States:
  - IDLE: ready=1.
  - START: div_start=1 for exactly one cycle.
  - WAIT: waiting for div_done.
  - RESULT: wb_done=1.
- IDLE + new_request: latch id, op, and rs1/rs2 raw values.
  - Signed ops: negate negative operands to form magnitudes.
  - neg_q = sign(rs1) XOR sign(rs2); neg_r = sign(rs1).
  - Unsigned ops: magnitudes = raw values, neg flags = 0.
- Next state from IDLE on new_request, in priority order:
  - rs2==0 → RESULT (zero fast path).
  - Else reuse hit → RESULT.
  - Else → START.
- Zero fast path: quotient = all ones; remainder = rs1 raw. Covers signed and unsigned. Divider is not started.
- Reuse hit: ENABLE_REUSE, entry valid, rs1/rs2 raw and signedness equal to stored. Use stored quotient/remainder, then apply sign correction.
- START → WAIT unconditionally.
- WAIT holds until div_done; on div_done, register the sign-corrected result and go to RESULT.
- Sign correction: DIV result = neg_q ? -q : q; REM result = neg_r ? -r : r; two's complement mod 2^DATA_WIDTH.
  - Overflow (MIN / -1) falls out naturally: result 0x80000000, remainder 0.
- On a divider completion, the reuse entry stores rs1/rs2 raw, signedness, unsigned q and r, and sets valid.
- RESULT holds wb_done, wb_id, wb_rd stable until wb_ack. On wb_ack: IDLE, with ready=1 the following cycle. No same-cycle re-accept.
- Latency (issue at T, divider done at D):
  - Divider path: wb_done at D+1.
  - Zero or reuse path: wb_done at T+1.
- div_dividend/div_divisor are registered in IDLE and stable from START through WAIT.
- new_request while ready=0 is a protocol error; assert in simulation, ignore in RTL.
- div_done outside WAIT is ignored.
- possible_issue is informational only; it does not gate acceptance.
- rst in any state: return to IDLE, drop any pending result, invalidate reuse entry, div_start=0 that cycle. A div_done arriving after reset is ignored.

Decomposition:
- Shared package taiga_types gains:
  - div_op_t enum (DIV, DIVU, REM, REMU).
  - div_fsm_t state enum.
  - Helper function is_signed_div_op.
- One natural sub-module: div_sign_fixup (combinational magnitude/negate and result correction). It is instantiated twice: operand side and result side.

Test Plan:
- DIV rs1=-20 (0xFFFFFFEC), rs2=3, divider returns q=6/r=2 → div_dividend=20, div_divisor=3, single div_start pulse, wb_rd=0xFFFFFFFA one cycle after div_done.
- DIVU rs1=7, rs2=0 → no div_start, wb_done at T+1, wb_rd=0xFFFFFFFF; then REM rs1=-7, rs2=0 → wb_rd=0xFFFFFFF9.
- DIV 0x80000000 / 0xFFFFFFFF → dividend 0x80000000, divisor 1, wb_rd=0x80000000; following REM same operands → reuse hit, no div_start, wb_rd=0.
- Hold wb_ack=0 for 5 cycles → wb_done/wb_id/wb_rd stable, ready=0; ack → ready=1 next cycle.
- Assert rst in WAIT, then pulse div_done → state IDLE, wb_done stays 0, next DIVU 9/2 restarts divider (no reuse hit), wb_rd=4.
- REMU 100/7 then DIVU 100/7 with ENABLE_REUSE=0 → two div_start pulses, results 2 and 14.

Source files
------------

// File: rtl/div_request_sequencer_pkg.sv
// div_request_sequencer_pkg: shared types for the divide request sequencer
package div_request_sequencer_pkg;
    typedef logic [3:0] id_t;
    typedef enum logic [1:0] {DIV = 2'd0, DIVU = 2'd1, REM = 2'd2, REMU = 2'd3} div_op_t;
    typedef enum logic [1:0] {IDLE, START, WAIT, RESULT} div_fsm_t;
    function automatic logic is_signed_div_op(div_op_t op);
        return ~op[0];
    endfunction
    function automatic logic is_rem_op(div_op_t op);
        return op[1];
    endfunction
endpackage

// File: rtl/div_request_sequencer_if.sv
// div_request_sequencer_if: issue, divider and writeback signals of the sequencer
// master = sequencer side, slave = issue/divider/writeback environment side
interface div_request_sequencer_if
    import div_request_sequencer_pkg::*;
#(
    parameter int DATA_WIDTH = 32
);
    logic possible_issue;
    logic new_request;
    id_t id;
    logic [DATA_WIDTH-1:0] rs1;
    logic [DATA_WIDTH-1:0] rs2;
    div_op_t op;
    logic ready;
    logic div_start;
    logic [DATA_WIDTH-1:0] div_dividend;
    logic [DATA_WIDTH-1:0] div_divisor;
    logic [DATA_WIDTH-1:0] div_quotient;
    logic [DATA_WIDTH-1:0] div_remainder;
    logic div_done;
    logic div_divisor_is_zero;
    logic wb_done;
    id_t wb_id;
    logic [DATA_WIDTH-1:0] wb_rd;
    logic wb_ack;
    modport master (
        input possible_issue, new_request, id, rs1, rs2, op,
        input div_quotient, div_remainder, div_done, div_divisor_is_zero, wb_ack,
        output ready, div_start, div_dividend, div_divisor, wb_done, wb_id, wb_rd
    );
    modport slave (
        output possible_issue, new_request, id, rs1, rs2, op,
        output div_quotient, div_remainder, div_done, div_divisor_is_zero, wb_ack,
        input ready, div_start, div_dividend, div_divisor, wb_done, wb_id, wb_rd
    );
endinterface

// File: rtl/div_request_sequencer_sign_fixup.sv
// div_request_sequencer_sign_fixup: conditional two's complement negate of two values
// a/b in, neg_a/neg_b select negation, y_a/y_b out
module div_request_sequencer_sign_fixup #(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    input  logic                  neg_a,
    input  logic                  neg_b,
    output logic [DATA_WIDTH-1:0] y_a,
    output logic [DATA_WIDTH-1:0] y_b
);
    assign y_a = neg_a ? -a : a;
    assign y_b = neg_b ? -b : b;
endmodule

// File: rtl/div_request_sequencer.sv
// div_request_sequencer: issues DIV/REM ops to a shared unsigned divider with sign fixup, zero fast path and result reuse
// clk/rst plain; bus (master) carries issue inputs, divider start/operands/results and the writeback slot
module div_request_sequencer
    import div_request_sequencer_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter bit ENABLE_REUSE = 1
) (
    input logic clk,
    input logic rst,
    div_request_sequencer_if.master bus
);
    localparam int W = DATA_WIDTH;
    div_fsm_t state;
    logic [W-1:0] lat_rs1, lat_rs2, mag1, mag2, q_s, r_s, fix_q, fix_r, res, zero_res;
    logic [W-1:0] reuse_rs1, reuse_rs2, reuse_q, reuse_r;
    logic lat_sgn, neg_q, neg_r, is_rem, reuse_sgn, reuse_valid;
    logic sgn_in, neg_q_in, neg_r_in, zero_in, hit, in_wait, unused_ok;
    assign unused_ok = bus.possible_issue;
    assign sgn_in   = is_signed_div_op(bus.op);
    assign neg_q_in = sgn_in & (bus.rs1[W-1] ^ bus.rs2[W-1]);
    assign neg_r_in = sgn_in & bus.rs1[W-1];
    assign zero_in  = bus.rs2 == '0;
    assign hit = ENABLE_REUSE && reuse_valid && bus.rs1 == reuse_rs1 && bus.rs2 == reuse_rs2 && sgn_in == reuse_sgn;
    assign in_wait = state == WAIT;
    // Divide by zero bypasses sign correction: quotient is all ones, remainder the raw dividend.
    assign zero_res = is_rem_op(bus.op) ? bus.rs1 : '1;
    div_request_sequencer_sign_fixup #(.DATA_WIDTH(W)) u_operand (
        .a(bus.rs1), .b(bus.rs2),
        .neg_a(sgn_in & bus.rs1[W-1]), .neg_b(sgn_in & bus.rs2[W-1]),
        .y_a(mag1), .y_b(mag2)
    );
    // The result fixup serves the divider completion in WAIT and the reuse hit in IDLE.
    assign q_s = in_wait ? bus.div_quotient : reuse_q;
    assign r_s = in_wait ? bus.div_remainder : reuse_r;
    div_request_sequencer_sign_fixup #(.DATA_WIDTH(W)) u_result (
        .a(q_s), .b(r_s),
        .neg_a(in_wait ? neg_q : neg_q_in), .neg_b(in_wait ? neg_r : neg_r_in),
        .y_a(fix_q), .y_b(fix_r)
    );
    assign res = (in_wait ? is_rem : is_rem_op(bus.op)) ? fix_r : fix_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            bus.ready        <= 1'b1;
            bus.div_start    <= 1'b0;
            bus.wb_done      <= 1'b0;
            bus.wb_id        <= '0;
            bus.wb_rd        <= '0;
            bus.div_dividend <= '0;
            bus.div_divisor  <= '0;
            reuse_valid      <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.new_request) begin
                    bus.wb_id        <= bus.id;
                    lat_rs1          <= bus.rs1;
                    lat_rs2          <= bus.rs2;
                    lat_sgn          <= sgn_in;
                    neg_q            <= neg_q_in;
                    neg_r            <= neg_r_in;
                    is_rem           <= is_rem_op(bus.op);
                    bus.div_dividend <= mag1;
                    bus.div_divisor  <= mag2;
                    bus.ready        <= 1'b0;
                    if (zero_in || hit) begin
                        bus.wb_rd   <= zero_in ? zero_res : res;
                        bus.wb_done <= 1'b1;
                        state       <= RESULT;
                    end else begin
                        bus.div_start <= 1'b1;
                        state         <= START;
                    end
                end
                START: begin
                    bus.div_start <= 1'b0;
                    state         <= WAIT;
                end
                WAIT: if (bus.div_done) begin
                    bus.wb_rd   <= res;
                    bus.wb_done <= 1'b1;
                    reuse_valid <= 1'b1;
                    reuse_rs1   <= lat_rs1;
                    reuse_rs2   <= lat_rs2;
                    reuse_sgn   <= lat_sgn;
                    reuse_q     <= bus.div_quotient;
                    reuse_r     <= bus.div_remainder;
                    state       <= RESULT;
                end
                RESULT: if (bus.wb_ack) begin
                    bus.wb_done <= 1'b0;
                    bus.ready   <= 1'b1;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
    a_issue_when_ready: assert property (@(posedge clk) disable iff (rst) bus.new_request |-> bus.ready);
    a_divider_nonzero: assert property (@(posedge clk) disable iff (rst) (in_wait && bus.div_done) |-> !bus.div_divisor_is_zero);
endmodule

// File: tb/tb_div_request_sequencer.sv
// tb_div_request_sequencer: directed checks of the divide request sequencer with and without reuse
module tb_div_request_sequencer;
    import div_request_sequencer_pkg::*;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int passed = 0;
    int starts0 = 0;
    int starts1 = 0;
    always #5 clk = ~clk;
    div_request_sequencer_if #(.DATA_WIDTH(32)) bus0 ();
    div_request_sequencer_if #(.DATA_WIDTH(32)) bus1 ();
    div_request_sequencer #(.DATA_WIDTH(32), .ENABLE_REUSE(1)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
    div_request_sequencer #(.DATA_WIDTH(32), .ENABLE_REUSE(0)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
    always @(posedge clk) begin
        if (bus0.div_start) starts0++;
        if (bus1.div_start) starts1++;
    end
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask
    task automatic issue(input bit d, input div_op_t op, input logic [31:0] a, input logic [31:0] b, input id_t id);
        @(negedge clk);
        if (d) begin
            bus1.op = op; bus1.rs1 = a; bus1.rs2 = b; bus1.id = id;
            bus1.possible_issue = 1'b1; bus1.new_request = 1'b1;
        end else begin
            bus0.op = op; bus0.rs1 = a; bus0.rs2 = b; bus0.id = id;
            bus0.possible_issue = 1'b1; bus0.new_request = 1'b1;
        end
        @(negedge clk);
        bus0.new_request = 1'b0; bus0.possible_issue = 1'b0;
        bus1.new_request = 1'b0; bus1.possible_issue = 1'b0;
    endtask
    task automatic finish_div(input bit d, input logic [31:0] q, input logic [31:0] r);
        @(negedge clk);
        if (d) begin
            bus1.div_quotient = q; bus1.div_remainder = r; bus1.div_done = 1'b1;
        end else begin
            bus0.div_quotient = q; bus0.div_remainder = r; bus0.div_done = 1'b1;
        end
        @(negedge clk);
        bus0.div_done = 1'b0;
        bus1.div_done = 1'b0;
    endtask
    task automatic ack(input bit d);
        @(negedge clk);
        if (d) bus1.wb_ack = 1'b1; else bus0.wb_ack = 1'b1;
        @(negedge clk);
        bus0.wb_ack = 1'b0;
        bus1.wb_ack = 1'b0;
    endtask
    initial begin
        bus0.possible_issue = 0; bus0.new_request = 0; bus0.id = '0; bus0.rs1 = '0; bus0.rs2 = '0; bus0.op = DIV;
        bus0.div_quotient = '0; bus0.div_remainder = '0; bus0.div_done = 0; bus0.div_divisor_is_zero = 0; bus0.wb_ack = 0;
        bus1.possible_issue = 0; bus1.new_request = 0; bus1.id = '0; bus1.rs1 = '0; bus1.rs2 = '0; bus1.op = DIV;
        bus1.div_quotient = '0; bus1.div_remainder = '0; bus1.div_done = 0; bus1.div_divisor_is_zero = 0; bus1.wb_ack = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("rst_ready", bus0.ready, 1);
        check("rst_div_start", bus0.div_start, 0);
        check("rst_wb_done", bus0.wb_done, 0);
        check("rst_wb_id", bus0.wb_id, 0);
        check("rst_wb_rd", bus0.wb_rd, 0);
        check("rst_dividend", bus0.div_dividend, 0);
        check("rst_divisor", bus0.div_divisor, 0);
        issue(0, DIV, 32'hFFFFFFEC, 32'd3, 4'd1);
        check("div_start", bus0.div_start, 1);
        check("div_dividend", bus0.div_dividend, 32'd20);
        check("div_divisor", bus0.div_divisor, 32'd3);
        check("div_ready", bus0.ready, 0);
        check("div_wb_early", bus0.wb_done, 0);
        finish_div(0, 32'd6, 32'd2);
        check("div_wb_done", bus0.wb_done, 1);
        check("div_wb_rd", bus0.wb_rd, 32'hFFFFFFFA);
        check("div_wb_id", bus0.wb_id, 4'd1);
        check("div_one_start", starts0, 1);
        ack(0);
        check("div_ready_after_ack", bus0.ready, 1);
        check("div_wb_dropped", bus0.wb_done, 0);
        issue(0, REM, 32'hFFFFFFEC, 32'd3, 4'd2);
        check("reuse_rem_wb_done", bus0.wb_done, 1);
        check("reuse_rem_wb_rd", bus0.wb_rd, 32'hFFFFFFFE);
        check("reuse_rem_no_start", bus0.div_start, 0);
        ack(0);
        issue(0, DIVU, 32'd7, 32'd0, 4'd3);
        check("zero_divu_wb_done", bus0.wb_done, 1);
        check("zero_divu_wb_rd", bus0.wb_rd, 32'hFFFFFFFF);
        check("zero_divu_no_start", bus0.div_start, 0);
        ack(0);
        issue(0, REM, 32'hFFFFFFF9, 32'd0, 4'd4);
        check("zero_rem_wb_done", bus0.wb_done, 1);
        check("zero_rem_wb_rd", bus0.wb_rd, 32'hFFFFFFF9);
        ack(0);
        check("zero_total_starts", starts0, 1);
        issue(0, DIV, 32'h80000000, 32'hFFFFFFFF, 4'd5);
        check("ovf_dividend", bus0.div_dividend, 32'h80000000);
        check("ovf_divisor", bus0.div_divisor, 32'd1);
        finish_div(0, 32'h80000000, 32'd0);
        check("ovf_wb_rd", bus0.wb_rd, 32'h80000000);
        ack(0);
        issue(0, REM, 32'h80000000, 32'hFFFFFFFF, 4'd6);
        check("ovf_rem_wb_done", bus0.wb_done, 1);
        check("ovf_rem_wb_rd", bus0.wb_rd, 32'd0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold_wb_done", bus0.wb_done, 1);
            check("hold_wb_id", bus0.wb_id, 4'd6);
            check("hold_wb_rd", bus0.wb_rd, 32'd0);
            check("hold_ready", bus0.ready, 0);
        end
        ack(0);
        check("hold_ready_after_ack", bus0.ready, 1);
        check("ovf_total_starts", starts0, 2);
        issue(0, DIVU, 32'd9, 32'd2, 4'd7);
        check("divu9_start", bus0.div_start, 1);
        finish_div(0, 32'd4, 32'd1);
        check("divu9_wb_rd", bus0.wb_rd, 32'd4);
        ack(0);
        issue(0, DIV, 32'd50, 32'd5, 4'd8);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bus0.div_quotient = 32'd10; bus0.div_remainder = 32'd0; bus0.div_done = 1'b1;
        @(negedge clk);
        bus0.div_done = 1'b0;
        check("rst_wait_wb_done", bus0.wb_done, 0);
        check("rst_wait_ready", bus0.ready, 1);
        check("rst_wait_div_start", bus0.div_start, 0);
        issue(0, DIVU, 32'd9, 32'd2, 4'd9);
        check("post_rst_restart", bus0.div_start, 1);
        finish_div(0, 32'd4, 32'd1);
        check("post_rst_wb_rd", bus0.wb_rd, 32'd4);
        check("post_rst_wb_id", bus0.wb_id, 4'd9);
        ack(0);
        issue(1, REMU, 32'd100, 32'd7, 4'd10);
        check("noreuse_remu_start", bus1.div_start, 1);
        finish_div(1, 32'd14, 32'd2);
        check("noreuse_remu_wb_rd", bus1.wb_rd, 32'd2);
        ack(1);
        issue(1, DIVU, 32'd100, 32'd7, 4'd11);
        check("noreuse_divu_start", bus1.div_start, 1);
        finish_div(1, 32'd14, 32'd2);
        check("noreuse_divu_wb_rd", bus1.wb_rd, 32'd14);
        check("noreuse_divu_wb_id", bus1.wb_id, 4'd11);
        ack(1);
        check("noreuse_starts", starts1, 2);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
